// File: rtl/arith_seq_pkg.sv
// arith_seq_pkg: shared op and state encodings for the arithmetic sequencer
package arith_seq_pkg;
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_RSV = 2'b11
  } op_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_MUL  = 2'b10,
    S_DONE = 2'b11
  } state_e;
endpackage

// File: rtl/arith_seq_ctrl_addsub_unit.sv
// addsub_unit: WIDTH-bit ripple adder; sub inverts y per bit and feeds carry-in
module addsub_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH-1:0] yx;
  logic [WIDTH:0]   c;
  assign c[0] = sub;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign yx[i]   = y[i] ^ sub;
    assign sum[i]  = x[i] ^ yx[i] ^ c[i];
    assign c[i+1]  = (x[i] & yx[i]) | (c[i] & (x[i] ^ yx[i]));
  end
  assign cout = c[WIDTH];
endmodule

// File: rtl/arith_seq_ctrl.sv
// arith_seq_ctrl: sequences one shared adder through add, sub and shift-and-add multiply
module arith_seq_ctrl
  import arith_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               flag,
  output logic               err
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_e             state;
  logic [WIDTH-1:0]   a_r, b_r, mreg;
  logic [1:0]         op_r;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   ax, ay, sum, mhi;
  logic               asub, cout, in_mul, mcarry;
  // multiply feeds acc_hi + a through the adder; add/sub feed the captured operands
  always_comb begin
    in_mul  = state == S_MUL;
    ax      = in_mul ? acc[2*WIDTH-1:WIDTH] : a_r;
    ay      = in_mul ? a_r : b_r;
    asub    = !in_mul && op_r == OP_SUB;
    mcarry  = mreg[0] & cout;
    mhi     = mreg[0] ? sum : acc[2*WIDTH-1:WIDTH];
    acc_nxt = {mcarry, mhi, acc[WIDTH-1:1]};
  end
  addsub_unit #(.WIDTH(WIDTH)) u_addsub (
    .x(ax), .y(ay), .sub(asub), .sum(sum), .cout(cout)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_r    <= '0;
      b_r    <= '0;
      op_r   <= '0;
      acc    <= '0;
      mreg   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      flag   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          a_r   <= a;
          b_r   <= b;
          op_r  <= op;
          busy  <= 1'b1;
          acc   <= '0;
          mreg  <= b;
          cnt   <= '0;
          state <= op == OP_MUL ? S_MUL : S_EXEC;
        end
        S_EXEC: begin
          busy   <= 1'b0;
          done   <= 1'b1;
          err    <= op_r == OP_RSV;
          flag   <= op_r == OP_ADD ? cout : op_r == OP_SUB ? ~cout : 1'b0;
          result <= op_r == OP_ADD ? {{(WIDTH-1){1'b0}}, cout, sum} :
                    op_r == OP_SUB ? {{WIDTH{1'b0}}, sum} : '0;
          state  <= S_DONE;
        end
        S_MUL: begin
          acc  <= acc_nxt;
          mreg <= mreg >> 1;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            result <= acc_nxt;
            flag   <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        default: begin
          done  <= 1'b0;
          err   <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
